// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Registers are placed every LEVELS_PER_STAGE prefix levels (stages S0..SK).
`timescale 1ns/1ps
module prefix_adder_pipe #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned LEVELS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned L = $clog2(WIDTH);
  localparam int unsigned K = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  // Applies prefix levels [lo, hi) to (g, p); returns G when want_p=0, else P.
  function automatic logic [WIDTH-1:0] prefix_span(
    input logic [WIDTH-1:0] g_in,
    input logic [WIDTH-1:0] p_in,
    input int unsigned      lo,
    input int unsigned      hi,
    input logic             want_p
  );
    logic [WIDTH-1:0] g, p, g_n, p_n;
    int unsigned      span;
    g = g_in;
    p = p_in;
    for (int unsigned d = lo; d < hi; d++) begin
      span = 1 << d;
      g_n  = g;
      p_n  = p;
      for (int unsigned i = span; i < WIDTH; i++) begin
        g_n[i] = g[i] | (p[i] & g[i-span]);
        p_n[i] = p[i] & p[i-span];
      end
      g = g_n;
      p = p_n;
    end
    return want_p ? p : g;
  endfunction

  function automatic int unsigned lvl_lo(input int unsigned s);
    return (s - 1) * LEVELS_PER_STAGE;
  endfunction

  function automatic int unsigned lvl_hi(input int unsigned s);
    return (s * LEVELS_PER_STAGE < L) ? s * LEVELS_PER_STAGE : L;
  endfunction

  logic [WIDTH-1:0] w_bp, w_p, w_g;
  logic             w_c;
  logic [K:0]       w_en;

  logic [K:0]                  r_v, r_cin, r_am, r_bm;
  logic [K:0][WIDTH-1:0]       r_G, r_po;
  logic [K-1:0][WIDTH-1:0]     r_P;

  assign w_bp = in_sub ? ~in_b : in_b;
  assign w_c  = in_sub | in_cin;
  assign w_p  = in_a ^ w_bp;
  assign w_g  = in_a & w_bp;

  // A stage can load when some stage at or after it is empty, or the sink drains.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    w_en     = '0;
    for (int unsigned i = 0; i <= K; i++) begin
      all_full = 1'b1;
      for (int unsigned j = i; j <= K; j++) begin
        all_full = all_full & r_v[j];
      end
      w_en[i] = out_ready | ~all_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_cin <= '0;
      r_am  <= '0;
      r_bm  <= '0;
      r_G   <= '0;
      r_po  <= '0;
      r_P   <= '0;
    end else begin
      if (w_en[0]) r_v[0] <= in_valid;
      if (w_en[0] && in_valid) begin
        r_G[0]   <= {w_g[WIDTH-1:1], w_g[0] | (w_p[0] & w_c)};
        r_P[0]   <= w_p;
        r_po[0]  <= w_p;
        r_cin[0] <= w_c;
        r_am[0]  <= in_a[WIDTH-1];
        r_bm[0]  <= w_bp[WIDTH-1];
      end
      for (int unsigned s = 1; s <= K; s++) begin
        if (w_en[s]) r_v[s] <= r_v[s-1];
        if (w_en[s] && r_v[s-1]) begin
          r_G[s]   <= prefix_span(r_G[s-1], r_P[s-1], lvl_lo(s), lvl_hi(s), 1'b0);
          r_po[s]  <= r_po[s-1];
          r_cin[s] <= r_cin[s-1];
          r_am[s]  <= r_am[s-1];
          r_bm[s]  <= r_bm[s-1];
        end
      end
      // Group-propagate is dead after the last level, so SK carries no P.
      for (int unsigned s = 1; s < K; s++) begin
        if (w_en[s] && r_v[s-1]) begin
          r_P[s] <= prefix_span(r_G[s-1], r_P[s-1], lvl_lo(s), lvl_hi(s), 1'b1);
        end
      end
    end
  end

  assign in_ready  = w_en[0];
  assign out_valid = r_v[K];
  assign out_sum   = r_po[K] ^ {r_G[K][WIDTH-2:0], r_cin[K]};
  assign out_cout  = r_G[K][WIDTH-1];
  assign out_ovf   = (r_am[K] == r_bm[K]) && (out_sum[WIDTH-1] != r_am[K]);

endmodule

// File: doc/prefix_adder_pipe.md
Name: prefix_adder_pipe

Overview:
- Parametrised, pipelined parallel-prefix (Kogge-Stone) adder/subtractor; successor to the fixed 8-bit combinational prefix adder.
- Generalised to WIDTH bits, with carry-in, carry-out, signed overflow and an add/sub mode.
- Pipeline registers are inserted every LEVELS_PER_STAGE prefix levels, and a valid/ready handshake provides full backpressure.
- Sits between operand-issue logic and result writeback in the arithmetic datapath.

Parameters:
- WIDTH, 32, operand/result width; power of two, 4..64.
- LEVELS_PER_STAGE, 2, prefix levels evaluated combinationally between pipeline registers; 1..log2(WIDTH).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transfer request
- in_ready  output  1  block can accept operands this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in; ignored when in_sub=1
- in_sub  input  1  0: A+B+cin; 1: A-B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of bit WIDTH-1; for sub, 1 means no borrow
- out_ovf  output  1  signed two's-complement overflow

Behaviour:
- L = log2(WIDTH). K = ceil(L / LEVELS_PER_STAGE). There are K+1 register stages, S0..SK, each with its own valid bit.
- S0 captures bitwise p = a^b', g = a&b', where b' = in_sub ? ~in_b : in_b, and c_in = in_sub ? 1 : in_cin.
- Carry-in is folded into bit 0: g0 = g0 | (p0 & c_in).
- Each prefix level d (span 2^d) combines with black cells: G = Gh | (Ph & Gl), P = Ph & Pl.
  - Positions i < 2^d pass through unchanged.
  - The original p vector, c_in, a[MSB] and b'[MSB] travel with the data through every stage.
- Outputs are driven from SK:
  - sum[0] = p0 ^ c_in
  - sum[i] = p_i ^ G[i-1:0]
  - cout = G[WIDTH-1:0]
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB])
- Latency: a transfer accepted on edge E drives out_valid=1 after edge E+K, provided no stall occurs. Defaults give K=3. WIDTH=8 with LPS=2 gives K=2.
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - Stage i advances when stage i+1 is empty or stage i+1 advances. SK advances when out_ready=1.
  - in_ready = !valid[S0] || S0 advances. This is combinational from out_ready through the stage valids, with no combinational path from in_valid.
  - Empty stages are filled by bubble collapse.
  - Throughput is 1 result/cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, out_sum, out_cout and out_ovf stay stable. No stage data or valid bit is lost or duplicated.
- Once asserted, out_valid is held until the output transfer.
- Results leave in strict issue order.
- Reset, asynchronous:
  - All stage valid bits are 0, so out_valid=0.
  - out_sum, out_cout and out_ovf are 0, because the data regs clear.
  - in_ready=1 from the first edge after rst_n deasserts.
  - Reset mid-operation discards all in-flight results; no result from before reset may appear afterwards.
- Wrap-around: the sum is modulo 2^WIDTH, and carry appears only on out_cout.
- Simultaneous input and output transfer on a full pipe is legal and keeps the pipe full.

Test Plan:
1. Reset with rst_n=0 mid-stream (2 results in flight) -> out_valid=0 and out_sum=0 immediately. After release, no stale result appears and in_ready=1.
2. WIDTH=32 add, a=0xFFFF_FFFF, b=0x0000_0001, cin=0, out_ready=1 -> after 3 cycles: sum=0x0000_0000, cout=1, ovf=0. Same with cin=1 -> sum=0x0000_0001, cout=1.
3. Sub, a=0x8000_0000, b=0x0000_0001 -> sum=0x7FFF_FFFF, cout=1, ovf=1. Then a=5, b=7 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
4. 64 back-to-back random transfers with out_ready=1 -> one result per cycle after the 3-cycle fill, in order, all matching the reference model (a±b).
5. Backpressure: fill with 4 ops, hold out_ready=0 for 5 cycles -> in_ready=0 once S0..S3 are full. Output stays constant. On release, all 4 results drain in order with none dropped.
6. WIDTH=8, LEVELS_PER_STAGE=1 -> latency 3. Exhaustive 256×256×{add, sub}×cin sweep matches the model.
